// File: rtl/mouse_pkg.sv
// mouse_pkg: shared constants and helpers for the mouse position tracker.
//   DELTA_W / BTN_W     : widths of the decoded PS/2 packet fields
//   BTN_L / BTN_R / BTN_M : bit positions inside the button vector
//   MODE_SAT / MODE_WRAP  : encoding of the wrap_mode input
//   bound_pos()           : clamp or wrap a signed candidate position into [0, max]
package mouse_pkg;

  localparam int DELTA_W = 9;
  localparam int BTN_W   = 3;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // A single correction is enough in wrap mode because a scaled delta never
  // exceeds max+1 in magnitude.
  function automatic int bound_pos(input int s, input int max_val, input logic mode);
    int r;
    r = s;
    if (s < 0) begin
      r = (mode == MODE_WRAP) ? (s + max_val + 1) : 0;
    end else if (s > max_val) begin
      r = (mode == MODE_WRAP) ? (s - (max_val + 1)) : max_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/mouse_pos_tracker_axis.sv
// mouse_axis_accum: one axis of the cursor position.
//   clk, rst             : clock and synchronous active-high reset (pos -> 0)
//   delta                : 9-bit two's-complement movement
//   mode                 : MODE_SAT / MODE_WRAP bound handling
//   load_max/min/mid     : absolute loads (caller guarantees at most one is set)
//   step                 : apply delta to the current position
//   pos                  : registered position, 0..MAX
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int AW      = 11,
  parameter int MAX     = 2047,
  parameter int GAIN_SH = 0,
  parameter int INV     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DELTA_W-1:0] delta,
  input  logic               mode,
  input  logic               load_min,
  input  logic               load_max,
  input  logic               load_mid,
  input  logic               step,
  output logic [AW-1:0]      pos
);

  // Two spare bits: one for the sign, one for position + delta overflow.
  localparam int SW = AW + GAIN_SH + 2;

  logic [AW-1:0]        pos_reg;
  logic [AW-1:0]        pos_next;
  logic signed [SW-1:0] delta_ext;
  logic signed [SW-1:0] delta_scaled;
  logic signed [SW-1:0] delta_adj;
  logic signed [SW-1:0] pos_ext;
  logic signed [SW-1:0] sum;

  assign delta_ext    = SW'($signed(delta));
  assign delta_scaled = delta_ext <<< GAIN_SH;
  // Negating -256<<GAIN_SH is safe: SW leaves room for +256<<GAIN_SH.
  assign delta_adj    = (INV != 0) ? -delta_scaled : delta_scaled;
  assign pos_ext      = $signed({{(GAIN_SH + 2){1'b0}}, pos_reg});
  assign sum          = pos_ext + delta_adj;
  assign pos_next     = AW'(bound_pos(int'(sum), MAX, mode));

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_reg <= '0;
    end else if (load_max) begin
      pos_reg <= AW'(MAX);
    end else if (load_min) begin
      pos_reg <= '0;
    end else if (load_mid) begin
      pos_reg <= AW'(MAX >> 1);
    end else if (step) begin
      pos_reg <= pos_next;
    end
  end

  assign pos = pos_reg;

endmodule

// File: rtl/mouse_pos_tracker.sv
// mouse_pos_tracker: turns decoded PS/2 mouse packets into absolute X/Y
// cursor positions, a one-hot LED bar driven by X, and an idle flag.
//   clk, rst      : clock and synchronous active-high reset
//   pkt_valid     : one-cycle strobe qualifying dx, dy, btn and wrap_mode
//   dx, dy        : 9-bit two's-complement deltas (dy positive = up)
//   btn           : button levels [0] left, [1] right, [2] middle
//   wrap_mode     : 0 saturate, 1 wrap
//   x_pos, y_pos  : registered positions, one cycle after the packet
//   led           : one-hot bar from the top bits of x_pos, one cycle after x_pos
//   pos_valid     : one-cycle pulse per accepted packet
//   btn_press     : rising-edge flags, aligned with pos_valid
//   idle          : high once IDLE_CYCLES packet-free cycles have elapsed
module mouse_pos_tracker
  import mouse_pkg::*;
#(
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int X_MAX       = 2047,
  parameter int Y_MAX       = 1023,
  parameter int GAIN_SH     = 0,
  parameter int Y_INV       = 0,
  parameter int N_LEDS      = 4,
  parameter int IDLE_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_valid,
  input  logic [DELTA_W-1:0] dx,
  input  logic [DELTA_W-1:0] dy,
  input  logic [BTN_W-1:0]   btn,
  input  logic               wrap_mode,
  output logic [X_W-1:0]     x_pos,
  output logic [Y_W-1:0]     y_pos,
  output logic [N_LEDS-1:0]  led,
  output logic               pos_valid,
  output logic [BTN_W-1:0]   btn_press,
  output logic               idle
);

  localparam int LW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  logic [BTN_W-1:0]  btn_prev_reg;
  logic [BTN_W-1:0]  press;
  logic              load_max;
  logic              load_min;
  logic              load_mid;
  logic              step;
  logic              pos_valid_reg;
  logic [BTN_W-1:0]  btn_press_reg;
  logic [N_LEDS-1:0] led_reg;
  logic [N_LEDS-1:0] led_next;
  logic [LW-1:0]     led_idx;
  logic [CW-1:0]     idle_cnt_reg;
  logic [CW-1:0]     idle_cnt_next;
  logic              idle_reg;

  assign press = btn & ~btn_prev_reg;

  // Right beats left beats middle; any press discards the packet's movement.
  assign load_max = pkt_valid & press[BTN_R];
  assign load_min = pkt_valid & press[BTN_L] & ~press[BTN_R];
  assign load_mid = pkt_valid & press[BTN_M] & ~press[BTN_L] & ~press[BTN_R];
  assign step     = pkt_valid & (press == '0);

  mouse_axis_accum #(
    .AW      (X_W),
    .MAX     (X_MAX),
    .GAIN_SH (GAIN_SH),
    .INV     (0)
  ) u_x_axis (
    .clk      (clk),
    .rst      (rst),
    .delta    (dx),
    .mode     (wrap_mode),
    .load_min (load_min),
    .load_max (load_max),
    .load_mid (load_mid),
    .step     (step),
    .pos      (x_pos)
  );

  mouse_axis_accum #(
    .AW      (Y_W),
    .MAX     (Y_MAX),
    .GAIN_SH (GAIN_SH),
    .INV     (Y_INV)
  ) u_y_axis (
    .clk      (clk),
    .rst      (rst),
    .delta    (dy),
    .mode     (wrap_mode),
    .load_min (load_min),
    .load_max (load_max),
    .load_mid (load_mid),
    .step     (step),
    .pos      (y_pos)
  );

  // LED decode reads the registered x_pos, hence the extra cycle of latency.
  assign led_idx = x_pos[X_W-1 -: LW];

  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
      assign led_next[gi] = (led_idx == LW'(gi));
    end
  endgenerate

  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (pkt_valid) begin
      idle_cnt_next = '0;
    end else if (idle_cnt_reg != CW'(IDLE_CYCLES)) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_reg  <= '0;
      pos_valid_reg <= 1'b0;
      btn_press_reg <= '0;
      led_reg       <= N_LEDS'(1);
      idle_cnt_reg  <= '0;
      idle_reg      <= 1'b0;
    end else begin
      pos_valid_reg <= pkt_valid;
      btn_press_reg <= pkt_valid ? press : '0;
      if (pkt_valid) begin
        btn_prev_reg <= btn;
      end
      led_reg      <= led_next;
      idle_cnt_reg <= idle_cnt_next;
      // Registered from the next count so idle rises on the edge the count
      // reaches IDLE_CYCLES.
      idle_reg     <= (idle_cnt_next == CW'(IDLE_CYCLES));
    end
  end

  assign pos_valid = pos_valid_reg;
  assign btn_press = btn_press_reg;
  assign led       = led_reg;
  assign idle      = idle_reg;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
module tb_mouse_pos_tracker;
  import mouse_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [8:0] dx = '0;
  logic [8:0] dy = '0;
  logic [2:0] btn = '0;
  logic       wrap_mode = 1'b0;

  logic [10:0] x_pos, x_pos_i;
  logic [9:0]  y_pos, y_pos_i;
  logic [3:0]  led, led_i;
  logic        pos_valid, pos_valid_i;
  logic [2:0]  btn_press, btn_press_i;
  logic        idle, idle_i;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mouse_pos_tracker #(.Y_INV(0), .IDLE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .dx(dx), .dy(dy), .btn(btn),
    .wrap_mode(wrap_mode), .x_pos(x_pos), .y_pos(y_pos), .led(led),
    .pos_valid(pos_valid), .btn_press(btn_press), .idle(idle)
  );

  mouse_pos_tracker #(.Y_INV(1), .IDLE_CYCLES(8)) dut_inv (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .dx(dx), .dy(dy), .btn(btn),
    .wrap_mode(wrap_mode), .x_pos(x_pos_i), .y_pos(y_pos_i), .led(led_i),
    .pos_valid(pos_valid_i), .btn_press(btn_press_i), .idle(idle_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one packet for a single cycle; returns 1 time unit after the
  // capturing edge, when the new position is visible.
  task automatic pkt(input logic [8:0] pdx, input logic [8:0] pdy,
                     input logic [2:0] pbtn, input logic pmode);
    dx = pdx; dy = pdy; btn = pbtn; wrap_mode = pmode; pkt_valid = 1'b1;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    $display("pkt dx=%0h dy=%0h btn=%b mode=%0d -> x=%0d y=%0d press=%b pv=%0d",
             pdx, pdy, pbtn, pmode, x_pos, y_pos, btn_press, pos_valid);
  endtask

  initial begin
    // Reset state
    tick(2);
    rst = 1'b0;
    check("rst_x", 32'(x_pos), 0);
    check("rst_y", 32'(y_pos), 0);
    check("rst_led", 32'(led), 1);
    check("rst_pv", 32'(pos_valid), 0);
    check("rst_bp", 32'(btn_press), 0);
    check("rst_idle", 32'(idle), 0);

    // Mid-stream reset
    pkt(9'd9, 9'd0, 3'b000, MODE_SAT);
    check("pre_rst_x", 32'(x_pos), 9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_x", 32'(x_pos), 0);

    // Basic movement and latency
    pkt(9'd5, 9'd3, 3'b000, MODE_SAT);
    check("mv_x", 32'(x_pos), 5);
    check("mv_y", 32'(y_pos), 3);
    check("mv_pv", 32'(pos_valid), 1);
    check("inv_y_sat0", 32'(y_pos_i), 0);
    tick(1);
    check("mv_pv_low", 32'(pos_valid), 0);
    check("mv_led", 32'(led), 4'b0001);

    // Right+left press: right wins, movement discarded
    pkt(9'd50, 9'd0, 3'b011, MODE_SAT);
    check("rl_x", 32'(x_pos), 2047);
    check("rl_y", 32'(y_pos), 1023);
    check("rl_bp", 32'(btn_press), 3'b011);
    pkt(9'h1F9, 9'd0, 3'b011, MODE_SAT);
    check("held_bp", 32'(btn_press), 0);
    check("held_x", 32'(x_pos), 2040);
    check("held_y", 32'(y_pos), 1023);

    // Saturation at top, then -256
    pkt(9'd20, 9'd1, 3'b000, MODE_SAT);
    check("sat_x", 32'(x_pos), 2047);
    check("sat_y", 32'(y_pos), 1023);
    pkt(9'h100, 9'd0, 3'b000, MODE_SAT);
    check("m256_x", 32'(x_pos), 1791);
    tick(1);
    check("m256_led", 32'(led), 4'b1000);

    // Wrap mode
    pkt(9'd249, 9'd0, 3'b000, MODE_SAT);
    check("to2040_x", 32'(x_pos), 2040);
    pkt(9'd20, 9'd0, 3'b000, MODE_WRAP);
    check("wrap_x", 32'(x_pos), 12);
    pkt(9'd0, 9'd0, 3'b001, MODE_WRAP);
    check("left_x", 32'(x_pos), 0);
    check("left_y", 32'(y_pos), 0);
    check("left_bp", 32'(btn_press), 3'b001);
    pkt(9'h1FF, 9'h1FF, 3'b000, MODE_WRAP);
    check("wrapneg_x", 32'(x_pos), 2047);
    check("wrapneg_y", 32'(y_pos), 1023);
    check("wrapneg_led_old", 32'(led), 4'b0001);
    tick(1);
    check("wrapneg_led", 32'(led), 4'b1000);
    pkt(9'd1, 9'd0, 3'b000, MODE_WRAP);
    check("wrapmax_x", 32'(x_pos), 0);
    pkt(9'h100, 9'd0, 3'b000, MODE_WRAP);
    check("wrap256_x", 32'(x_pos), 1792);

    // Middle press, then held middle with dy on both Y polarities
    pkt(9'd0, 9'd10, 3'b100, MODE_SAT);
    check("mid_bp", 32'(btn_press), 3'b100);
    check("mid_x", 32'(x_pos), 1023);
    check("mid_y", 32'(y_pos), 511);
    check("mid_inv_y", 32'(y_pos_i), 511);
    pkt(9'd0, 9'd10, 3'b100, MODE_SAT);
    check("dy_bp", 32'(btn_press), 0);
    check("dy_y", 32'(y_pos), 521);
    check("dy_inv_y", 32'(y_pos_i), 501);

    // Idle timeout: rises exactly 8 cycles after the last packet
    tick(7);
    check("idle_7", 32'(idle), 0);
    tick(1);
    check("idle_8", 32'(idle), 1);
    tick(3);
    check("idle_hold", 32'(idle), 1);
    pkt(9'd0, 9'd0, 3'b000, MODE_SAT);
    check("idle_clr", 32'(idle), 0);
    check("idle_clr_pv", 32'(pos_valid), 1);

    // Reset with a simultaneous packet: packet dropped
    rst = 1'b1; pkt_valid = 1'b1; dx = 9'd5; dy = 9'd5; btn = 3'b010;
    tick(1);
    rst = 1'b0; pkt_valid = 1'b0;
    check("rp_x", 32'(x_pos), 0);
    check("rp_y", 32'(y_pos), 0);
    check("rp_led", 32'(led), 1);
    check("rp_pv", 32'(pos_valid), 0);
    check("rp_bp", 32'(btn_press), 0);
    check("rp_idle", 32'(idle), 0);
    tick(1);
    check("rp_pv2", 32'(pos_valid), 0);
    pkt(9'd0, 9'd0, 3'b010, MODE_SAT);
    check("rp_press", 32'(btn_press), 3'b010);
    check("rp_press_x", 32'(x_pos), 2047);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
